// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared definitions for the neuron MAC sequencer: default widths and the
// sequencer state encoding. The BIAS state exists only when the optional
// bias preload feature (NEURON_SEQ_BIAS_EN) is compiled in.
package neuron_mac_sequencer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_SHIFT  = 4;

    typedef enum logic [2:0] {
        IDLE,
`ifdef NEURON_SEQ_BIAS_EN
        BIAS,
`endif
        FETCH_X,
        FETCH_W,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// RAM bus between the sequencer (master) and a dual-port RAM (slave).
// Read data is combinational from the read address; writes commit on the
// clock edge that ends the cycle in which ram_wre is high.
interface neuron_mac_sequencer_if
    import neuron_mac_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0] ram_read_address;
    logic              ram_oe;
    logic [DATA_W-1:0] ram_read_data;
    logic [ADDR_W-1:0] ram_write_address;
    logic [DATA_W-1:0] ram_write_data;
    logic              ram_wre;

    modport master (
        output ram_read_address,
        output ram_oe,
        input  ram_read_data,
        output ram_write_address,
        output ram_write_data,
        output ram_wre
    );

    modport slave (
        input  ram_read_address,
        input  ram_oe,
        output ram_read_data,
        input  ram_write_address,
        input  ram_write_data,
        input  ram_wre
    );

endinterface

// File: rtl/neuron_mac_unit.sv
// Datapath of the neuron sequencer: holds the current input operand x,
// multiplies it by the weight on the read bus and accumulates the product
// into an accumulator that saturates at all-ones instead of wrapping.
module neuron_mac_unit
    import neuron_mac_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_bias,
    input  logic              latch_x,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] read_data,
    output logic [ACC_W-1:0]  acc
);

    logic [DATA_W-1:0]   x;
    logic [2*DATA_W-1:0] product;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    bias_init;

    assign product   = x * read_data;
    assign sum       = {1'b0, acc} + (ACC_W + 1)'(product);
    assign bias_init = ACC_W'(read_data) << SHIFT;

    // Operand capture and saturating multiply-accumulate; clear wins over load, load over accumulate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x   <= '0;
            acc <= '0;
        end else begin
            if (latch_x) begin
                x <= read_data;
            end
            if (clear) begin
                acc <= '0;
            end else if (load_bias) begin
                acc <= bias_init;
            end else if (accumulate) begin
                acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Neuron evaluation sequencer: reads N input/weight pairs from RAM,
// accumulates their products, scales and saturates the sum and writes it
// back. Optional macro NEURON_SEQ_BIAS_EN adds a BIAS state that seeds the
// accumulator from RAM (value << SHIFT) before the first term.
module neuron_mac_sequencer
    import neuron_mac_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_terms,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] out_addr,
    input  logic [ADDR_W-1:0] bias_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    neuron_mac_sequencer_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] next_i;
    logic [ADDR_W-1:0] n_reg;
    logic [ADDR_W-1:0] x_base_reg;
    logic [ADDR_W-1:0] w_base_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [ADDR_W-1:0] read_addr_reg;
    logic              oe_reg;
    logic              wre_reg;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0] write_value;
    logic              clear_acc;
    logic              load_bias;

    assign next_i      = i + 1'b1;
    assign shifted     = acc >> SHIFT;
    assign write_value = (|(shifted >> DATA_W)) ? '1 : shifted[DATA_W-1:0];
    assign clear_acc   = (state == IDLE) && start;

`ifdef NEURON_SEQ_BIAS_EN
    assign load_bias = (state == BIAS);
`else
    logic unused_bias_addr;
    assign load_bias        = 1'b0;
    assign unused_bias_addr = ^bias_addr;
`endif

    assign bus.ram_read_address  = read_addr_reg;
    assign bus.ram_oe            = oe_reg;
    assign bus.ram_write_address = out_addr_reg;
    assign bus.ram_write_data    = write_value;
    assign bus.ram_wre           = wre_reg;

    neuron_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_acc),
        .load_bias  (load_bias),
        .latch_x    (state == FETCH_X),
        .accumulate (state == FETCH_W),
        .read_data  (bus.ram_read_data),
        .acc        (acc)
    );

    // Sequencer FSM; RAM strobes and read address are set up on the edge entering each state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            i             <= '0;
            n_reg         <= '0;
            x_base_reg    <= '0;
            w_base_reg    <= '0;
            out_addr_reg  <= '0;
            read_addr_reg <= '0;
            oe_reg        <= 1'b0;
            wre_reg       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg        <= n_terms;
                        x_base_reg   <= x_base;
                        w_base_reg   <= w_base;
                        out_addr_reg <= out_addr;
                        i            <= '0;
                        busy         <= 1'b1;
`ifdef NEURON_SEQ_BIAS_EN
                        state         <= BIAS;
                        oe_reg        <= 1'b1;
                        read_addr_reg <= bias_addr;
`else
                        if (n_terms == '0) begin
                            state   <= WRITE;
                            wre_reg <= 1'b1;
                        end else begin
                            state         <= FETCH_X;
                            oe_reg        <= 1'b1;
                            read_addr_reg <= x_base;
                        end
`endif
                    end
                end
`ifdef NEURON_SEQ_BIAS_EN
                BIAS: begin
                    if (n_reg == '0) begin
                        state   <= WRITE;
                        oe_reg  <= 1'b0;
                        wre_reg <= 1'b1;
                    end else begin
                        state         <= FETCH_X;
                        read_addr_reg <= x_base_reg;
                    end
                end
`endif
                FETCH_X: begin
                    state         <= FETCH_W;
                    read_addr_reg <= w_base_reg + i;
                end
                FETCH_W: begin
                    i <= next_i;
                    if (next_i == n_reg) begin
                        state   <= WRITE;
                        oe_reg  <= 1'b0;
                        wre_reg <= 1'b1;
                    end else begin
                        state         <= FETCH_X;
                        read_addr_reg <= x_base_reg + next_i;
                    end
                end
                WRITE: begin
                    state   <= DONE;
                    wre_reg <= 1'b0;
                    done    <= 1'b1;
                    result  <= write_value;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    oe_reg  <= 1'b0;
                    wre_reg <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_mac_sequencer.md
NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

Interface
REQ-001 Parameter DATA_W, 8, RAM data width and operand width (unsigned).
REQ-002 Parameter ADDR_W, 8, RAM address width.
REQ-003 Parameter ACC_W, 24, accumulator width.
REQ-004 Parameter SHIFT, 4, right-shift applied to the accumulator before output saturation.
REQ-005 Port clk, in, 1, single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, in, 1, reset, synchronous, active-low.
REQ-007 Port start, in, 1, request one neuron evaluation; sampled only in IDLE.
REQ-008 Port n_terms, in, ADDR_W, number of input/weight pairs N (0..255); sampled with start.
REQ-009 Port x_base / w_base / out_addr / bias_addr, in, ADDR_W each, base addresses of inputs, weights, result and bias; sampled with start.
REQ-010 Port busy, out, 1, high in every state except IDLE.
REQ-011 Port done, out, 1, one-cycle completion pulse.
REQ-012 Port result, out, DATA_W, last value written to RAM.
REQ-013 Port ram_read_address, out, ADDR_W, RAM read address.
REQ-014 Port ram_oe, out, 1, RAM output enable.
REQ-015 Port ram_read_data, in, DATA_W, RAM combinational read data.
REQ-016 Port ram_write_address / ram_write_data, out, ADDR_W / DATA_W, RAM write address and data.
REQ-017 Port ram_wre, out, 1, RAM write enable; the RAM commits on the clk edge that ends the cycle.

Function
REQ-018 The FSM SHALL have the states IDLE, BIAS (macro only), FETCH_X, FETCH_W, WRITE and DONE.
- Transitions: IDLE->(BIAS|FETCH_X|WRITE) on start.
- FETCH_X->FETCH_W.
- FETCH_W->FETCH_X while terms remain, else WRITE.
- WRITE->DONE.
- DONE->IDLE.
REQ-019 On the edge that samples start, the block SHALL latch its inputs, clear term index i and clear the accumulator.
REQ-020 In FETCH_X the block SHALL drive ram_oe=1 and ram_read_address=x_base+i, and SHALL latch ram_read_data into the x register.
REQ-021 In FETCH_W the block SHALL drive ram_oe=1 and ram_read_address=w_base+i, SHALL add x*ram_read_data (2*DATA_W-bit unsigned product, zero-extended) to the accumulator, and SHALL increment i.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-023 When n_terms=0, the block SHALL go directly to WRITE (or BIAS then WRITE) with no fetches.
REQ-024 In WRITE the block SHALL drive the following for exactly one cycle, and SHALL load the same value into result:
- ram_wre=1
- ram_write_address=out_addr
- ram_write_data=min(acc>>SHIFT, 2^DATA_W-1)
REQ-025 The accumulator SHALL saturate at 2^ACC_W-1 and SHALL NOT wrap.
REQ-026 ram_oe and ram_wre SHALL be 0 in all other states; ram_oe SHALL never be 1 in WRITE.
REQ-027 Latency: with start sampled at edge E0, the WRITE cycle SHALL be cycle 2N+1 and done SHALL be high in cycle 2N+2 (macro off).
REQ-028 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 start held high continuously SHALL begin a new evaluation on the first edge after DONE (IDLE sampled).

Reset
REQ-030 With rst_n=0 at an edge, the state SHALL become IDLE and the following SHALL be cleared: accumulator, i, x, result=0, busy=0, done=0, ram_oe=0, ram_wre=0.
REQ-031 Reset mid-operation SHALL abort the evaluation with no RAM write and no done pulse.

Configuration
REQ-032 Macro NEURON_SEQ_BIAS_EN: when defined, a BIAS state SHALL follow IDLE.
- BIAS drives ram_oe=1 and ram_read_address=bias_addr.
- BIAS initialises acc=ram_read_data<<SHIFT.
- All latencies grow by one cycle (WRITE at 2N+2, done at 2N+3).
REQ-033 Without NEURON_SEQ_BIAS_EN, no BIAS state SHALL exist, bias_addr SHALL be ignored, and the accumulator SHALL start at 0.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the default widths (DATA_W, ADDR_W, ACC_W, SHIFT).
REQ-035 One sub-module, neuron_mac_unit, SHALL contain the x register, the multiplier, and the saturating accumulator with its clear/load/accumulate controls.
REQ-036 The FSM and address generation SHALL stay in the top module.

Verification
REQ-037 The bench SHALL couple the block to a dual-port RAM model (combinational read, write-bypass, write on clk edge) preloaded so that mem[0..7] = 10,11,5,2,4,5,3,2.
REQ-038 Test 1: x_base=0, w_base=4, N=4, out_addr=16, SHIFT=4 -> acc=114, mem[16]=7, result=7, wre in cycle 9, done in cycle 10 only.
REQ-039 Test 2: preload mem[32..35]=255, x_base=32, w_base=34, N=2 -> acc=130050, mem[out_addr]=255 (saturated).
REQ-040 Test 3: N=0, out_addr=20 -> mem[20]=0, no oe cycles, done in cycle 2.
REQ-041 Test 4: Test 1 with start re-pulsed in cycle 3 and rst_n=0 at cycle 5 -> no write to mem[16], busy=0 and result=0 after the reset edge, and a later start runs normally.
REQ-042 Test 5 (NEURON_SEQ_BIAS_EN): Test 1 with bias_addr=1 -> acc=176+114=290, mem[16]=18, done in cycle 11.
